jimmy_io_peripheral: RTL and testbench
======================================

# jimmy_io_peripheral

Port-side peripheral for the `jimmy` core's four 8-bit I/O ports. It captures every `OUTPUT` the core performs into a tagged FIFO, which a host drains with a valid/ready handshake. It also holds host-supplied bytes on the core's input ports and marks them consumed when the core executes `INPUT`. The block connects directly to the core's `out_port_*`, `out_strobe`, `in_port_*` and `in_strobe` pins.

## Interface
Parameters:
- `DEPTH`, 8: capture FIFO entries (power of two, ≥2)
- `CW`, 4: width of `cap_count` (log2(DEPTH)+1)

Ports:
- `jimmy_clk`  in  1  single clock, rising edge
- `reset`  in  1  synchronous, active-high; all state cleared on the clock edge where it is 1
- `out_port_0..3`  in  8 each  core output port data
- `out_strobe`  in  4  core output strobes, active-low, one-cycle pulse
- `in_strobe`  in  4  core input strobes, active-low, one-cycle pulse
- `in_port_0..3`  out  8 each  bytes presented to the core
- `cap_valid`  out  1  FIFO head valid
- `cap_ready`  in  1  host accepts head
- `cap_port`  out  2  port index of head entry
- `cap_data`  out  8  data of head entry
- `cap_count`  out  CW  FIFO occupancy
- `ld_valid`  in  1  host load request
- `ld_ready`  out  1  load accepted when high with `ld_valid`
- `ld_port`  in  2  target input port
- `ld_data`  in  8  byte to load
- `in_full`  out  4  input holding register i holds an unread byte
- `ovf`  out  4  sticky: output event on port i lost
- `udr`  out  4  sticky: core read port i while empty
- `clr_flags`  in  1  clears `ovf` and `udr`

## Operation
- Edge detect: `prev_out`/`prev_in` registers, reset 4'b1111. Event on bit i = (prev==1 && strobe==0). A strobe held low yields one event.
- Output capture: on an out event, `pend[i]<=1` and `pdata[i]<=out_port_i`.
  - New event on a port whose `pend` is already set and is not pushed this cycle: keep the old data, drop the new byte, set `ovf[i]`.
  - If the pending entry is pushed in the same cycle as a new event, the new byte becomes pending. No overflow.
- FIFO write arbiter: each cycle, push the lowest-index pending port if `cap_count<DEPTH`. The push clears that `pend`. At most one push per cycle.
- FIFO: entry = {port[1:0], data[7:0]}. Pop when `cap_valid && cap_ready`. When `0<count<DEPTH`, push and pop in the same cycle leave the count unchanged. Pointers wrap modulo DEPTH.
- Input side: holding registers `hold[i]`; `in_port_i = hold[i]`.
  - `ld_ready = !in_full[ld_port]`. A load sets `hold[ld_port]<=ld_data` and `in_full[ld_port]<=1`.
  - An in event on port i clears `in_full[i]`. `hold[i]` keeps its value.
  - An in event on port i while `in_full[i]==0` sets `udr[i]`.
  - Load and underrun event on the same empty port in the same cycle: the load completes (`in_full=1`) and `udr` is still set.
  - Load on a full port blocks, even when a strobe empties it that cycle. The load succeeds on the next cycle.
- `clr_flags` clears `ovf`/`udr`. A set condition in the same cycle wins.
- States per output port: IDLE (pend=0) → PEND on event → IDLE on push.
- States per input port: EMPTY → FULL on load → EMPTY on event.

## Timing
- Reset values: `in_port_*`=0, `in_full`=0, `cap_valid`=0, `cap_port`=0, `cap_data`=0, `cap_count`=0, `ovf`=0, `udr`=0, `ld_ready`=1. Pending entries, FIFO contents and pointers are cleared. `prev_*`=4'b1111.
- Reset mid-operation discards pending entries, FIFO contents and held bytes.
- Out latency: strobe sampled low at edge E0 → pending at E0 → pushed at E1 → `cap_valid`/`cap_data` valid after E1 (not full).
- Multiple simultaneous events: pushed in index order on consecutive cycles.
- In latency: strobe sampled low at E0 → `in_full[i]` low after E0. `ld_ready` is combinational from `ld_port` and `in_full`.
- `cap_*` are registered outputs: the FIFO head driven from storage and the count register.

## Test plan
- Reset with `out_strobe`=4'b1111; pulse `out_strobe[2]` low one cycle with `out_port_2`=8'hA5 → `cap_valid` after 2 edges, `cap_port`=2, `cap_data`=8'hA5, `cap_count`=1; pop → count 0.
- Simultaneous pulses on ports 3 and 0 (8'h11, 8'h33) → FIFO order {0,8'h11} then {3,8'h33}, `ovf`=0.
- `cap_ready`=0; 9 events on port 1 (data 1..9) with DEPTH=8 → count 8, byte 9 pending; 10th event → `ovf[1]`=1; drain → 1..9 in order.
- Load port 1 with 8'h7E → `in_full[1]`=1, `in_port_1`=8'h7E, second load `ld_ready`=0; `in_strobe[1]` pulse → `in_full[1]`=0, `udr`=0.
- `in_strobe[3]` pulse with port 3 empty → `udr[3]`=1; `clr_flags` → 0.
- Assert `reset` with FIFO count 3 and `in_full`=4'b0101 → all outputs at reset values next cycle.

Source files
------------

// File: rtl/jimmy_io_peripheral.sv
// Port-side peripheral for the jimmy core: captures OUTPUT events into a tagged FIFO
// and holds host-loaded bytes on the core's input ports until the core reads them.
module jimmy_io_peripheral #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned CW    = 4
) (
  input  logic          jimmy_clk,
  input  logic          reset,
  input  logic [7:0]    out_port_0,
  input  logic [7:0]    out_port_1,
  input  logic [7:0]    out_port_2,
  input  logic [7:0]    out_port_3,
  input  logic [3:0]    out_strobe,
  input  logic [3:0]    in_strobe,
  output logic [7:0]    in_port_0,
  output logic [7:0]    in_port_1,
  output logic [7:0]    in_port_2,
  output logic [7:0]    in_port_3,
  output logic          cap_valid,
  input  logic          cap_ready,
  output logic [1:0]    cap_port,
  output logic [7:0]    cap_data,
  output logic [CW-1:0] cap_count,
  input  logic          ld_valid,
  output logic          ld_ready,
  input  logic [1:0]    ld_port,
  input  logic [7:0]    ld_data,
  output logic [3:0]    in_full,
  output logic [3:0]    ovf,
  output logic [3:0]    udr,
  input  logic          clr_flags
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [3:0]    prev_out_q, prev_in_q;
  logic [3:0]    out_ev, in_ev;
  logic [3:0]    pend_q, pend_d;
  logic [7:0]    pdata_q [4];
  logic [7:0]    pdata_d [4];
  logic [7:0]    out_data [4];
  logic [9:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q;
  logic          push, pop, load;
  logic [1:0]    push_sel;
  logic [3:0]    push_oh;
  logic [7:0]    hold_q [4];
  logic [7:0]    hold_d [4];
  logic [3:0]    full_q, full_d;
  logic [3:0]    ovf_q, ovf_d, ovf_set;
  logic [3:0]    udr_q, udr_d, udr_set;

  assign out_data[0] = out_port_0;
  assign out_data[1] = out_port_1;
  assign out_data[2] = out_port_2;
  assign out_data[3] = out_port_3;

  // Strobes are active-low; a falling edge is one event regardless of how long it stays low.
  assign out_ev = prev_out_q & ~out_strobe;
  assign in_ev  = prev_in_q & ~in_strobe;

  always_comb begin
    push_sel = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (pend_q[i]) push_sel = 2'(i);
    end
    push    = (|pend_q) && (count_q < CW'(DEPTH));
    push_oh = push ? (4'b0001 << push_sel) : 4'b0000;
    pop     = cap_valid && cap_ready;
  end

  always_comb begin
    pend_d  = pend_q;
    pdata_d = pdata_q;
    ovf_set = 4'b0000;
    for (int i = 0; i < 4; i++) begin
      if (out_ev[i]) begin
        // A pending byte that is not leaving this cycle is kept; the newcomer is lost.
        if (pend_q[i] && !push_oh[i]) begin
          ovf_set[i] = 1'b1;
        end else begin
          pend_d[i]  = 1'b1;
          pdata_d[i] = out_data[i];
        end
      end else if (push_oh[i]) begin
        pend_d[i] = 1'b0;
      end
    end
  end

  always_comb begin
    ld_ready = !full_q[ld_port];
    load     = ld_valid && ld_ready;
    full_d   = full_q;
    hold_d   = hold_q;
    for (int i = 0; i < 4; i++) begin
      if (load && (ld_port == 2'(i))) begin
        full_d[i] = 1'b1;
        hold_d[i] = ld_data;
      end else if (in_ev[i]) begin
        full_d[i] = 1'b0;
      end
    end
    udr_set = in_ev & ~full_q;
    ovf_d   = (clr_flags ? 4'b0000 : ovf_q) | ovf_set;
    udr_d   = (clr_flags ? 4'b0000 : udr_q) | udr_set;
  end

  always_ff @(posedge jimmy_clk) begin
    if (reset) begin
      prev_out_q <= 4'b1111;
      prev_in_q  <= 4'b1111;
      pend_q     <= 4'b0000;
      full_q     <= 4'b0000;
      ovf_q      <= 4'b0000;
      udr_q      <= 4'b0000;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      for (int i = 0; i < 4; i++) begin
        pdata_q[i] <= 8'h00;
        hold_q[i]  <= 8'h00;
      end
      for (int j = 0; j < int'(DEPTH); j++) begin
        mem_q[j] <= 10'h000;
      end
    end else begin
      prev_out_q <= out_strobe;
      prev_in_q  <= in_strobe;
      pend_q     <= pend_d;
      pdata_q    <= pdata_d;
      full_q     <= full_d;
      hold_q     <= hold_d;
      ovf_q      <= ovf_d;
      udr_q      <= udr_d;
      if (push) begin
        mem_q[wr_ptr_q] <= {push_sel, pdata_q[push_sel]};
        wr_ptr_q        <= wr_ptr_q + AW'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
      end
      case ({push, pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  assign cap_valid = (count_q != '0);
  assign cap_port  = mem_q[rd_ptr_q][9:8];
  assign cap_data  = mem_q[rd_ptr_q][7:0];
  assign cap_count = count_q;
  assign in_full   = full_q;
  assign ovf       = ovf_q;
  assign udr       = udr_q;
  assign in_port_0 = hold_q[0];
  assign in_port_1 = hold_q[1];
  assign in_port_2 = hold_q[2];
  assign in_port_3 = hold_q[3];

endmodule

// File: tb/tb_jimmy_io_peripheral.sv
// Directed bench for jimmy_io_peripheral: capture entries are predicted into a queue when
// strobes are driven and compared as the host drains the FIFO.
module tb_jimmy_io_peripheral;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] out_port_0, out_port_1, out_port_2, out_port_3;
  logic [3:0] out_strobe, in_strobe;
  logic [7:0] in_port_0, in_port_1, in_port_2, in_port_3;
  logic       cap_valid, cap_ready;
  logic [1:0] cap_port;
  logic [7:0] cap_data;
  logic [3:0] cap_count;
  logic       ld_valid, ld_ready;
  logic [1:0] ld_port;
  logic [7:0] ld_data;
  logic [3:0] in_full, ovf, udr;
  logic       clr_flags;

  int n_assert = 0;
  int n_fail   = 0;
  logic [9:0] sb [$];

  always #5 clk = ~clk;

  jimmy_io_peripheral #(.DEPTH(8), .CW(4)) dut (
    .jimmy_clk (clk),
    .reset     (reset),
    .out_port_0(out_port_0),
    .out_port_1(out_port_1),
    .out_port_2(out_port_2),
    .out_port_3(out_port_3),
    .out_strobe(out_strobe),
    .in_strobe (in_strobe),
    .in_port_0 (in_port_0),
    .in_port_1 (in_port_1),
    .in_port_2 (in_port_2),
    .in_port_3 (in_port_3),
    .cap_valid (cap_valid),
    .cap_ready (cap_ready),
    .cap_port  (cap_port),
    .cap_data  (cap_data),
    .cap_count (cap_count),
    .ld_valid  (ld_valid),
    .ld_ready  (ld_ready),
    .ld_port   (ld_port),
    .ld_data   (ld_data),
    .in_full   (in_full),
    .ovf       (ovf),
    .udr       (udr),
    .clr_flags (clr_flags)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Compare the FIFO head against the oldest prediction, then pop it for one cycle.
  task automatic pop_check(input string tag);
    logic [9:0] exp;
    chk({tag, "_valid"}, 32'(cap_valid), 32'd1);
    if (sb.size() == 0) begin
      chk({tag, "_sb_empty"}, 32'(sb.size()), 32'd1);
    end else begin
      exp = sb.pop_front();
      chk(tag, {22'd0, cap_port, cap_data}, {22'd0, exp});
    end
    cap_ready = 1'b1;
    tick();
    cap_ready = 1'b0;
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, "_cap_valid"}, 32'(cap_valid), 32'd0);
    chk({tag, "_cap_count"}, 32'(cap_count), 32'd0);
    chk({tag, "_cap_head"}, {22'd0, cap_port, cap_data}, 32'd0);
    chk({tag, "_in_full"}, 32'(in_full), 32'd0);
    chk({tag, "_flags"}, {24'd0, ovf, udr}, 32'd0);
    chk({tag, "_ld_ready"}, 32'(ld_ready), 32'd1);
    chk({tag, "_in_ports"}, {in_port_3, in_port_2, in_port_1, in_port_0}, 32'd0);
  endtask

  initial begin
    reset = 1'b1;
    out_port_0 = 8'h00; out_port_1 = 8'h00; out_port_2 = 8'h00; out_port_3 = 8'h00;
    out_strobe = 4'b1111; in_strobe = 4'b1111;
    cap_ready = 1'b0; ld_valid = 1'b0; ld_port = 2'd0; ld_data = 8'h00; clr_flags = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    check_reset_state("reset");

    // Single capture on port 2
    out_port_2 = 8'hA5; out_strobe = 4'b1011; sb.push_back({2'd2, 8'hA5});
    tick();
    out_strobe = 4'b1111;
    chk("lat_not_yet", 32'(cap_valid), 32'd0);
    tick();
    chk("single_count", 32'(cap_count), 32'd1);
    pop_check("single_head");
    chk("single_drained", 32'(cap_count), 32'd0);

    // Simultaneous events on ports 3 and 0 go out in index order
    out_port_0 = 8'h11; out_port_3 = 8'h33; out_strobe = 4'b0110;
    sb.push_back({2'd0, 8'h11});
    sb.push_back({2'd3, 8'h33});
    tick();
    out_strobe = 4'b1111;
    tick();
    tick();
    chk("simul_count", 32'(cap_count), 32'd2);
    pop_check("simul_first");
    pop_check("simul_second");
    chk("simul_ovf", 32'(ovf), 32'd0);

    // Fill the FIFO from port 1: eight stored, ninth pending, tenth lost
    for (int k = 1; k <= 10; k++) begin
      out_port_1 = 8'(k); out_strobe = 4'b1101;
      if (k <= 9) sb.push_back({2'd1, 8'(k)});
      tick();
      out_strobe = 4'b1111;
      if (k == 9) begin
        chk("full_count", 32'(cap_count), 32'd8);
        chk("full_no_ovf", 32'(ovf), 32'd0);
      end
      tick();
    end
    chk("full_ovf", 32'(ovf), 32'b0010);
    chk("full_count_hold", 32'(cap_count), 32'd8);
    for (int k = 1; k <= 9; k++) begin
      pop_check("drain");
    end
    chk("drain_empty", 32'(cap_count), 32'd0);
    chk("drain_valid", 32'(cap_valid), 32'd0);

    // Input load, blocked second load, then core read
    ld_port = 2'd1; ld_data = 8'h7E; ld_valid = 1'b1;
    chk("ld_ready_empty", 32'(ld_ready), 32'd1);
    tick();
    ld_data = 8'h55;
    chk("ld_full", 32'(in_full), 32'b0010);
    chk("ld_data", 32'(in_port_1), 32'h7E);
    chk("ld_ready_full", 32'(ld_ready), 32'd0);
    tick();
    ld_valid = 1'b0;
    chk("ld_blocked", 32'(in_port_1), 32'h7E);
    in_strobe = 4'b1101;
    tick();
    in_strobe = 4'b1111;
    chk("rd_empty", 32'(in_full), 32'd0);
    chk("rd_no_udr", 32'(udr), 32'd0);
    chk("rd_hold_kept", 32'(in_port_1), 32'h7E);

    // Underrun on port 3, then load and underrun together on port 2
    in_strobe = 4'b0111;
    tick();
    in_strobe = 4'b1111;
    chk("udr3", 32'(udr), 32'b1000);
    ld_port = 2'd2; ld_data = 8'hBB; ld_valid = 1'b1; in_strobe = 4'b1011;
    tick();
    ld_valid = 1'b0; in_strobe = 4'b1111;
    chk("ld_udr_full", 32'(in_full), 32'b0100);
    chk("ld_udr_flag", 32'(udr), 32'b1100);
    chk("ld_udr_data", 32'(in_port_2), 32'hBB);
    clr_flags = 1'b1;
    tick();
    clr_flags = 1'b0;
    chk("clr_flags", {24'd0, ovf, udr}, 32'd0);

    // Reset with three FIFO entries and two full input ports
    out_port_0 = 8'h01; out_port_1 = 8'h02; out_port_2 = 8'h03; out_strobe = 4'b1000;
    ld_port = 2'd0; ld_data = 8'hAA; ld_valid = 1'b1;
    tick();
    out_strobe = 4'b1111; ld_valid = 1'b0;
    tick();
    tick();
    tick();
    chk("pre_reset_count", 32'(cap_count), 32'd3);
    chk("pre_reset_full", 32'(in_full), 32'b0101);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    sb.delete();
    check_reset_state("midreset");
    tick();
    tick();
    chk("post_reset_count", 32'(cap_count), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
